// File: rtl/axi_r_resp_router_if.sv
// AXI read-data channel bundle. ID_W/DATA_W size the slave-side (tagged) or
// master-side (tag stripped) flavour of the channel.
interface axi_r_resp_router_if #(
  parameter int ID_W   = 4,
  parameter int DATA_W = 32
) ();
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  // AXI master side: receives read data, returns ready
  modport master (
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  // AXI slave side: produces read data, observes ready
  modport slave (
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_r_resp_router.sv
// Read-data return router for a 2-master/2-slave interconnect.
// Locks onto one slave R channel for a whole burst and steers each beat to the
// master named by the tag in the upper RID bits, stripping that tag on the way.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no slave owned; arbitrate S0/S1 (tie broken by prio)
// LOCK_S0 | burst from S0 routed combinationally until its RLAST handshake
// LOCK_S1 | burst from S1 routed combinationally until its RLAST handshake
module axi_r_resp_router #(
  parameter int ID_BITS   = 4,
  parameter int IDS_BITS  = 8,
  parameter int DATA_BITS = 32,
  parameter int M0_TAG    = 0,
  parameter int M1_TAG    = 1
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  axi_r_resp_router_if.master    s0,
  axi_r_resp_router_if.master    s1,
  axi_r_resp_router_if.slave     m0,
  axi_r_resp_router_if.slave     m1,
  output logic                   busy,
  output logic                   tag_err
);

  localparam int TAG_BITS = IDS_BITS - ID_BITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCK_S0 = 2'd1,
    LOCK_S1 = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic                  prio, prio_nxt;
  logic                  tag_err_nxt;

  logic [IDS_BITS-1:0]   sel_id;
  logic [DATA_BITS-1:0]  sel_data;
  logic [1:0]            sel_resp;
  logic                  sel_last;
  logic                  sel_valid;
  logic                  sel_ready;
  logic [TAG_BITS-1:0]   sel_tag;
  logic                  locked;
  logic                  to_m0;
  logic                  to_m1;
  logic                  hs;

  // select the locked slave's channel; nothing is selected while idle
  always_comb begin
    sel_id    = '0;
    sel_data  = '0;
    sel_resp  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    case (state)
      LOCK_S0: begin
        sel_id    = s0.rid;
        sel_data  = s0.rdata;
        sel_resp  = s0.rresp;
        sel_last  = s0.rlast;
        sel_valid = s0.rvalid;
      end
      LOCK_S1: begin
        sel_id    = s1.rid;
        sel_data  = s1.rdata;
        sel_resp  = s1.rresp;
        sel_last  = s1.rlast;
        sel_valid = s1.rvalid;
      end
      default: ;
    endcase
  end

  assign locked  = (state != IDLE);
  assign sel_tag = sel_id[IDS_BITS-1:ID_BITS];
  assign to_m0   = locked && (sel_tag == TAG_BITS'(M0_TAG));
  assign to_m1   = locked && !to_m0 && (sel_tag == TAG_BITS'(M1_TAG));

  // steer the beat to the tagged master; the other master sees all zeros
  always_comb begin
    m0.rvalid = 1'b0;
    m0.rid    = '0;
    m0.rdata  = '0;
    m0.rresp  = '0;
    m0.rlast  = 1'b0;
    m1.rvalid = 1'b0;
    m1.rid    = '0;
    m1.rdata  = '0;
    m1.rresp  = '0;
    m1.rlast  = 1'b0;
    if (to_m0) begin
      m0.rvalid = sel_valid;
      m0.rid    = sel_id[ID_BITS-1:0];
      m0.rdata  = sel_data;
      m0.rresp  = sel_resp;
      m0.rlast  = sel_last;
    end else if (to_m1) begin
      m1.rvalid = sel_valid;
      m1.rid    = sel_id[ID_BITS-1:0];
      m1.rdata  = sel_data;
      m1.rresp  = sel_resp;
      m1.rlast  = sel_last;
    end
  end

  // an unknown tag is sunk (ready forced high) so the slave cannot stall the bus
  always_comb begin
    sel_ready = 1'b0;
    if (to_m0)       sel_ready = m0.rready;
    else if (to_m1)  sel_ready = m1.rready;
    else if (locked) sel_ready = 1'b1;
  end

  assign s0.rready = (state == LOCK_S0) && sel_ready;
  assign s1.rready = (state == LOCK_S1) && sel_ready;
  assign hs        = sel_valid && sel_ready;
  assign busy      = locked;

  // next-state: arbitrate in IDLE, release on the RLAST handshake and flip priority
  always_comb begin
    state_nxt   = state;
    prio_nxt    = prio;
    tag_err_nxt = hs && !to_m0 && !to_m1;
    case (state)
      IDLE: begin
        if (s0.rvalid && (!s1.rvalid || !prio)) state_nxt = LOCK_S0;
        else if (s1.rvalid)                     state_nxt = LOCK_S1;
      end
      LOCK_S0: begin
        if (hs && sel_last) begin
          state_nxt = IDLE;
          prio_nxt  = 1'b1;
        end
      end
      LOCK_S1: begin
        if (hs && sel_last) begin
          state_nxt = IDLE;
          prio_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state, priority and the registered unknown-tag pulse
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state   <= IDLE;
      prio    <= 1'b0;
      tag_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      prio    <= prio_nxt;
      tag_err <= tag_err_nxt;
    end
  end

endmodule

// File: tb/tb_axi_r_resp_router.sv
// Directed bench for axi_r_resp_router with a per-master expected-beat queue.
module tb_axi_r_resp_router;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, tag_err;

  axi_r_resp_router_if #(.ID_W(8), .DATA_W(32)) s0_if ();
  axi_r_resp_router_if #(.ID_W(8), .DATA_W(32)) s1_if ();
  axi_r_resp_router_if #(.ID_W(4), .DATA_W(32)) m0_if ();
  axi_r_resp_router_if #(.ID_W(4), .DATA_W(32)) m1_if ();

  axi_r_resp_router #(
    .ID_BITS(4), .IDS_BITS(8), .DATA_BITS(32), .M0_TAG(0), .M1_TAG(1)
  ) dut (
    .ACLK(clk), .ARESETn(rst_n),
    .s0(s0_if), .s1(s1_if), .m0(m0_if), .m1(m1_if),
    .busy(busy), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  int    pass_cnt = 0;
  int    total_cnt = 0;
  int    fail_cnt = 0;
  int    cyc = 0;
  int    m0_beats = 0;
  int    m1_beats = 0;
  int    tag_err_cnt = 0;
  beat_t exp_m0[$];
  beat_t exp_m1[$];
  int    hs_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slave(input int s, input logic v, input logic [7:0] id,
                           input logic [31:0] d, input logic [1:0] r, input logic l);
    if (s == 0) begin
      s0_if.rvalid = v; s0_if.rid = id; s0_if.rdata = d; s0_if.rresp = r; s0_if.rlast = l;
    end else begin
      s1_if.rvalid = v; s1_if.rid = id; s1_if.rdata = d; s1_if.rresp = r; s1_if.rlast = l;
    end
  endtask

  function automatic logic slave_ready(input int s);
    return (s == 0) ? s0_if.rready : s1_if.rready;
  endfunction

  task automatic push_exp(input int m, input logic [3:0] id, input logic [31:0] d,
                          input logic [1:0] r, input logic l);
    beat_t b;
    b.id = id; b.data = d; b.resp = r; b.last = l;
    if (m == 0) exp_m0.push_back(b);
    else        exp_m1.push_back(b);
  endtask

  task automatic exp_burst(input int m, input logic [7:0] id, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++)
      push_exp(m, id[3:0], base + 32'(i), 2'(i), (i == n - 1));
  endtask

  // drives one burst, waiting (bounded) for each beat's handshake
  task automatic drive_burst(input int s, input logic [7:0] id, input int n, input logic [31:0] base);
    logic hs;
    for (int i = 0; i < n; i++) begin
      set_slave(s, 1'b1, id, base + 32'(i), 2'(i), (i == n - 1));
      hs = 1'b0;
      for (int c = 0; c < 50 && !hs; c++) begin
        @(negedge clk);
        hs = slave_ready(s);
        @(posedge clk);
        #1;
      end
      chk("slave handshake", 64'(hs), 64'd1);
    end
    set_slave(s, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (tag_err) tag_err_cnt++;

  // master-side monitors: pop and compare every accepted beat
  always @(negedge clk) begin
    beat_t e;
    if (m0_if.rvalid && m0_if.rready) begin
      m0_beats++;
      hs_log.push_back(cyc);
      chk("m0 queue empty", 64'(exp_m0.size() == 0), 64'd0);
      if (exp_m0.size() != 0) begin
        e = exp_m0.pop_front();
        chk("m0 beat", 64'({m0_if.rid, m0_if.rdata, m0_if.rresp, m0_if.rlast}), 64'(e));
      end
    end else if (!m0_if.rvalid) begin
      chk("m0 idle payload", 64'({m0_if.rid, m0_if.rdata, m0_if.rresp, m0_if.rlast}), 64'd0);
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (m1_if.rvalid && m1_if.rready) begin
      m1_beats++;
      hs_log.push_back(cyc);
      chk("m1 queue empty", 64'(exp_m1.size() == 0), 64'd0);
      if (exp_m1.size() != 0) begin
        e = exp_m1.pop_front();
        chk("m1 beat", 64'({m1_if.rid, m1_if.rdata, m1_if.rresp, m1_if.rlast}), 64'(e));
      end
    end else if (!m1_if.rvalid) begin
      chk("m1 idle payload", 64'({m1_if.rid, m1_if.rdata, m1_if.rresp, m1_if.rlast}), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    set_slave(0, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
    set_slave(1, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
    m0_if.rready = 1'b1;
    m1_if.rready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst tag_err", 64'(tag_err), 64'd0);
    chk("rst s0 rready", 64'(s0_if.rready), 64'd0);
    chk("rst s1 rready", 64'(s1_if.rready), 64'd0);
    chk("rst m0 rvalid", 64'(m0_if.rvalid), 64'd0);
    chk("rst m1 rvalid", 64'(m1_if.rvalid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1) S0 4-beat burst tagged for M1
    exp_burst(1, 8'h13, 4, 32'hA000_0000);
    fork
      drive_burst(0, 8'h13, 4, 32'hA000_0000);
      begin
        @(negedge clk);
        chk("t1 idle cycle m1 rvalid", 64'(m1_if.rvalid), 64'd0);
        chk("t1 idle cycle s0 rready", 64'(s0_if.rready), 64'd0);
        chk("t1 idle cycle busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("t1 grant m1 rvalid", 64'(m1_if.rvalid), 64'd1);
        chk("t1 grant busy", 64'(busy), 64'd1);
        chk("t1 grant m1 rid", 64'(m1_if.rid), 64'h3);
        chk("t1 grant m0 rvalid", 64'(m0_if.rvalid), 64'd0);
      end
    join
    @(negedge clk);
    chk("t1 busy after", 64'(busy), 64'd0);
    chk("t1 m1 beats", 64'(m1_beats), 64'd4);
    chk("t1 m0 beats", 64'(m0_beats), 64'd0);

    // 2) tie after reset: S0 first, then S1 wins the next tie
    reset_dut();
    exp_burst(0, 8'h01, 2, 32'hB000_0000);
    exp_burst(0, 8'h05, 3, 32'hC000_0000);
    exp_burst(0, 8'h02, 2, 32'hD000_0000);
    fork
      begin
        drive_burst(0, 8'h01, 2, 32'hB000_0000);
        drive_burst(0, 8'h02, 2, 32'hD000_0000);
      end
      drive_burst(1, 8'h05, 3, 32'hC000_0000);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("t2 tie s0 rready", 64'(s0_if.rready), 64'd1);
        chk("t2 tie s1 rready", 64'(s1_if.rready), 64'd0);
      end
    join
    @(negedge clk);
    chk("t2 m0 queue drained", 64'(exp_m0.size()), 64'd0);

    // 3) S1 burst to M0 with 3 cycles of master backpressure
    exp_burst(0, 8'h05, 6, 32'hE000_0000);
    b = m0_beats;
    fork
      drive_burst(1, 8'h05, 6, 32'hE000_0000);
      begin
        for (int c = 0; c < 50 && m0_beats < b + 2; c++) begin
          @(negedge clk); #1;
        end
        chk("t3 two beats seen", 64'(m0_beats - b), 64'd2);
        @(posedge clk); #1;
        m0_if.rready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("t3 s1 rready held", 64'(s1_if.rready), 64'd0);
          chk("t3 m0 rvalid held", 64'(m0_if.rvalid), 64'd1);
          chk("t3 m0 rdata held", 64'(m0_if.rdata), 64'hE000_0002);
          @(posedge clk); #1;
        end
        m0_if.rready = 1'b1;
      end
    join
    chk("t3 m0 beats", 64'(m0_beats - b), 64'd6);

    // 4) unknown tag single beat is sunk
    set_slave(0, 1'b1, 8'h72, 32'hF000_0000, 2'b00, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4 s0 rready sink", 64'(s0_if.rready), 64'd1);
    chk("t4 m0 rvalid", 64'(m0_if.rvalid), 64'd0);
    chk("t4 m1 rvalid", 64'(m1_if.rvalid), 64'd0);
    chk("t4 tag_err not yet", 64'(tag_err), 64'd0);
    @(posedge clk); #1;
    set_slave(0, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
    @(negedge clk);
    chk("t4 tag_err pulse", 64'(tag_err), 64'd1);
    chk("t4 busy idle", 64'(busy), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4 tag_err cleared", 64'(tag_err), 64'd0);

    // 5) reset at beat 2 of an 8-beat burst; prio returns to S0
    push_exp(1, 4'h0, 32'h1000_0000, 2'd0, 1'b0);
    @(posedge clk); #1;
    set_slave(0, 1'b1, 8'h10, 32'h1000_0000, 2'd0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    set_slave(0, 1'b1, 8'h10, 32'h1000_0001, 2'd1, 1'b0);
    set_slave(1, 1'b1, 8'h00, 32'h2000_0001, 2'd0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5 m1 rvalid on reset", 64'(m1_if.rvalid), 64'd0);
    chk("t5 s0 rready on reset", 64'(s0_if.rready), 64'd0);
    chk("t5 s1 rready on reset", 64'(s1_if.rready), 64'd0);
    chk("t5 busy on reset", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    set_slave(0, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
    set_slave(1, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
    chk("t5 m1 beats", 64'(m1_beats), 64'd5);
    rst_n = 1'b1;
    exp_burst(0, 8'h00, 1, 32'h3000_0000);
    exp_burst(0, 8'h00, 1, 32'h4000_0000);
    fork
      drive_burst(0, 8'h00, 1, 32'h3000_0000);
      drive_burst(1, 8'h00, 1, 32'h4000_0000);
    join

    // 6) back-to-back single-beat bursts from S0, alternating masters
    @(negedge clk);
    hs_log.delete();
    @(posedge clk); #1;
    exp_burst(0, 8'h0A, 1, 32'h5000_0000);
    exp_burst(1, 8'h1B, 1, 32'h5000_0001);
    exp_burst(0, 8'h0C, 1, 32'h5000_0002);
    exp_burst(1, 8'h1D, 1, 32'h5000_0003);
    drive_burst(0, 8'h0A, 1, 32'h5000_0000);
    drive_burst(0, 8'h1B, 1, 32'h5000_0001);
    drive_burst(0, 8'h0C, 1, 32'h5000_0002);
    drive_burst(0, 8'h1D, 1, 32'h5000_0003);
    @(negedge clk);
    chk("t6 beat count", 64'(hs_log.size()), 64'd4);
    for (int i = 1; i < hs_log.size(); i++)
      chk("t6 b2b interval", 64'(hs_log[i] - hs_log[i-1]), 64'd2);

    // end of run bookkeeping
    chk("end m0 queue empty", 64'(exp_m0.size()), 64'd0);
    chk("end m1 queue empty", 64'(exp_m1.size()), 64'd0);
    chk("end tag_err pulses", 64'(tag_err_cnt), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
